// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ requesters.
// Each accepted command occupies the port for one CMD cycle, plus one RESP cycle for reads.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    localparam int LG_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy,
    output logic [LG_W-1:0]               last_grant
);

    // state | meaning
    // IDLE  | waiting for a valid request, arbitration active
    // CMD   | memory port driven with the captured command
    // RESP  | read data returning to the captured requester
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t          state;
    logic            cap_write;
    logic [LG_W-1:0] cap_idx;
    logic            found;
    logic [LG_W-1:0] winner;
    logic [LG_W-1:0] cand;

    // Search starts one past the last grant and wraps at NUM_REQ, so
    // indices beyond NUM_REQ-1 are never considered.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LG_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[winner] = 1'b1;
    end

    assign rsp_rdata = (state == RESP) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LG_W'(NUM_REQ - 1);
            cap_write  <= 1'b0;
            cap_idx    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            rsp_valid  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (found) begin
                        state      <= CMD;
                        last_grant <= winner;
                        cap_write  <= req_write[winner];
                        cap_idx    <= winner;
                        mem_en     <= 1'b1;
                        mem_we     <= req_write[winner];
                        mem_addr   <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata  <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                        busy       <= 1'b1;
                    end
                end
                CMD: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (cap_write) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= NUM_REQ'(1) << cap_idx;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= '0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic [1:0]      last_grant;

    logic [DW-1:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    mem_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant)
    );

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, busy, rsp_valid, rsp_rdata, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b we=%b addr=%h wd=%h busy=%b rv=%b rd=%h rdy=%b expected all 0",
                     mem_en, mem_we, mem_addr, mem_wdata, busy, rsp_valid, rsp_rdata, req_ready);
        end
        checks++;
        if (last_grant !== 2'd3) begin
            errors++;
            $display("FAIL reset_last_grant: got %0d expected 3", last_grant);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req_valid = 4'b0100; req_write = 4'b0000; req_addr[2*AW +: AW] = 8'h10;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL read_ready: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, busy, last_grant, req_ready} !== {1'b1, 1'b0, 8'h10, 1'b1, 2'd2, 4'b0000}) begin
            errors++;
            $display("FAIL read_cmd: en=%b we=%b addr=%h busy=%b lg=%0d rdy=%b expected 1 0 10 1 2 0000",
                     mem_en, mem_we, mem_addr, busy, last_grant, req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_rdata, mem_en} !== {4'b0100, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp: rv=%b rd=%h en=%b expected 0100 deadbeef 0", rsp_valid, rsp_rdata, mem_en);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL read_done: rv=%b rd=%h busy=%b expected 0", rsp_valid, rsp_rdata, busy);
        end
    endtask

    task automatic test_write_readback();
        req_valid = 4'b0001; req_write = 4'b0001;
        req_addr[0 +: AW] = 8'h05; req_wdata[0 +: DW] = 32'h12345678;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wr_ready: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h05, 32'h12345678}) begin
            errors++;
            $display("FAIL wr_cmd: en=%b we=%b addr=%h wd=%h expected 1 1 05 12345678", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, mem_en, mem_we, busy} !== '0) begin
            errors++;
            $display("FAIL wr_no_rsp: rv=%b en=%b we=%b busy=%b expected 0", rsp_valid, mem_en, mem_we, busy);
        end
        req_valid = 4'b0001; req_write = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rb_ready: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h05}) begin
            errors++; $display("FAIL rb_cmd: en=%b we=%b addr=%h expected 1 0 05", mem_en, mem_we, mem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0001, 32'h12345678}) begin
            errors++; $display("FAIL rb_rsp: rv=%b rd=%h expected 0001 12345678", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        rst = 1'b1;
        req_valid = 4'b1111; req_write = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = AW'(8'h20 + i);
            req_wdata[i*DW +: DW] = DW'(32'hA000_0000 + i);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
            if (c % 2 == 1) begin
                checks++;
                if ({mem_en, mem_addr, last_grant} !== {1'b1, AW'(8'h20 + ((c / 2) % 4)), 2'((c / 2) % 4)}) begin
                    errors++;
                    $display("FAIL rr_cmd c=%0d: en=%b addr=%h lg=%0d expected 1 %h %0d",
                             c, mem_en, mem_addr, last_grant, 8'h20 + ((c / 2) % 4), (c / 2) % 4);
                end
            end
            if (c == 11) req_valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_skip();
        req_valid = 4'b0100; req_write = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (last_grant !== 2'd2) begin
            errors++; $display("FAIL wrap_setup: lg=%0d expected 2", last_grant);
        end
        req_valid = 4'b1010; req_write = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_first: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, last_grant} !== {4'b0010, 2'd3}) begin
            errors++; $display("FAIL wrap_second: rdy=%b lg=%0d expected 0010 3", req_ready, last_grant);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (last_grant !== 2'd1) begin
            errors++; $display("FAIL wrap_end: lg=%0d expected 1", last_grant);
        end
    endtask

    task automatic test_reset_mid_read();
        req_valid = 4'b0010; req_write = 4'b0000; req_addr[1*AW +: AW] = 8'h10;
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
            errors++; $display("FAIL mid_cmd: en=%b we=%b addr=%h expected 1 0 10", mem_en, mem_we, mem_addr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, busy, rsp_valid, rsp_rdata, last_grant} !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0000, 32'h0, 2'd3}) begin
            errors++;
            $display("FAIL mid_reset: en=%b we=%b addr=%h busy=%b rv=%b lg=%0d expected zeros lg=3",
                     mem_en, mem_we, mem_addr, busy, rsp_valid, last_grant);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({rsp_valid, busy} !== '0) begin
                errors++; $display("FAIL mid_no_rsp c=%0d: rv=%b busy=%b expected 0", c, rsp_valid, busy);
            end
            @(negedge clk);
        end
        req_valid = 4'b1010; req_write = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_next_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if ({mem_en, busy, req_ready} !== '0) begin
                errors++; $display("FAIL idle c=%0d: en=%b busy=%b rdy=%b expected 0", c, mem_en, busy, req_ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem_rdata = '0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_round_robin();
        test_wrap_skip();
        test_reset_mid_read();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
